// File: rtl/matcher_pkg.sv
// Shared types and constants for the vocabulary lookup sequencer.
package matcher_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        COMPARE    = 3'd2,
        SKIP_FETCH = 3'd3,
        SKIP_CHECK = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam int NUL = 0;

endpackage

// File: rtl/vocab_lookup_ctrl.sv
// Looks up one NUL-terminated query word in a list of NUL-terminated vocab words
// by walking two 1-cycle-latency SRAMs; reports hit, word index and start address.
module vocab_lookup_ctrl
    import matcher_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] word_idx,
    output logic [ADDR_WIDTH-1:0] match_addr,
    output logic [ADDR_WIDTH-1:0] vocab_addr,
    input  logic [DATA_WIDTH-1:0] vocab_dout,
    output logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [DATA_WIDTH-1:0] input_dout,
    output state_t                state_dbg
);

    // Handshake: start is a level sampled only in IDLE; busy covers every
    // non-IDLE cycle; done is a one-cycle pulse during which the result is valid.

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] NUL_CH   = DATA_WIDTH'(NUL);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] vocab_addr_nxt, input_addr_nxt;
    logic [ADDR_WIDTH-1:0] word_start, word_start_nxt;
    logic [ADDR_WIDTH-1:0] idx, idx_nxt;
    logic [ADDR_WIDTH-1:0] word_idx_nxt, match_addr_nxt;
    logic                  hit_nxt;
    logic                  next_word;
    logic                  v_nul, at_max;

    assign v_nul     = (vocab_dout == NUL_CH);
    assign at_max    = (vocab_addr == ADDR_MAX);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vocab_addr <= '0;
            input_addr <= '0;
            word_start <= '0;
            idx        <= '0;
            hit        <= 1'b0;
            word_idx   <= '0;
            match_addr <= '0;
        end else begin
            state      <= state_nxt;
            vocab_addr <= vocab_addr_nxt;
            input_addr <= input_addr_nxt;
            word_start <= word_start_nxt;
            idx        <= idx_nxt;
            hit        <= hit_nxt;
            word_idx   <= word_idx_nxt;
            match_addr <= match_addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        vocab_addr_nxt = vocab_addr;
        input_addr_nxt = input_addr;
        word_start_nxt = word_start;
        idx_nxt        = idx;
        hit_nxt        = hit;
        word_idx_nxt   = word_idx;
        match_addr_nxt = match_addr;
        next_word      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    vocab_addr_nxt = '0;
                    input_addr_nxt = '0;
                    word_start_nxt = '0;
                    idx_nxt        = '0;
                    hit_nxt        = 1'b0;
                    state_nxt      = FETCH;
                end
            end
            FETCH: state_nxt = COMPARE;
            COMPARE: begin
                // An empty word marks end of list; checked first so an empty query misses.
                if (v_nul && (vocab_addr == word_start)) begin
                    state_nxt = DONE;
                end else if (v_nul && (input_dout == NUL_CH)) begin
                    hit_nxt        = 1'b1;
                    word_idx_nxt   = idx;
                    match_addr_nxt = word_start;
                    state_nxt      = DONE;
                end else if (vocab_dout == input_dout) begin
                    if (at_max) begin
                        state_nxt = DONE;
                    end else begin
                        vocab_addr_nxt = vocab_addr + 1'b1;
                        input_addr_nxt = input_addr + 1'b1;
                        state_nxt      = FETCH;
                    end
                end else if (v_nul) begin
                    next_word = 1'b1;
                end else if (at_max) begin
                    state_nxt = DONE;
                end else begin
                    vocab_addr_nxt = vocab_addr + 1'b1;
                    state_nxt      = SKIP_FETCH;
                end
            end
            SKIP_FETCH: state_nxt = SKIP_CHECK;
            SKIP_CHECK: begin
                if (v_nul) begin
                    next_word = 1'b1;
                end else if (at_max) begin
                    state_nxt = DONE;
                end else begin
                    vocab_addr_nxt = vocab_addr + 1'b1;
                    state_nxt      = SKIP_FETCH;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Shared by COMPARE and SKIP_CHECK once the current word's terminator is seen.
        if (next_word) begin
            if (at_max) begin
                state_nxt = DONE;
            end else begin
                word_start_nxt = vocab_addr + 1'b1;
                vocab_addr_nxt = vocab_addr + 1'b1;
                input_addr_nxt = '0;
                idx_nxt        = idx + 1'b1;
                state_nxt      = FETCH;
            end
        end
    end

endmodule

// File: tb/tb_vocab_lookup_ctrl.sv
// Self-checking bench for vocab_lookup_ctrl with behavioural SRAM models.
module tb_vocab_lookup_ctrl;
    import matcher_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, hit;
    logic [AW-1:0] word_idx, match_addr, vocab_addr, input_addr;
    logic [DW-1:0] vocab_dout, input_dout;
    state_t        state_dbg;

    logic [DW-1:0] vocab_mem [16];
    logic [DW-1:0] query_mem [16];

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    logic [AW-1:0] prev_vaddr = '0;
    logic          wrap_seen = 1'b0;

    // Expected result word: {hit, word_idx, match_addr}
    logic [2*AW:0] exp_q[$];

    vocab_lookup_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .hit(hit),
        .word_idx(word_idx), .match_addr(match_addr),
        .vocab_addr(vocab_addr), .vocab_dout(vocab_dout),
        .input_addr(input_addr), .input_dout(input_dout),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vocab_dout <= vocab_mem[vocab_addr];
        input_dout <= query_mem[input_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and vocab_addr monotonicity monitor.
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else check("result", {23'd0, hit, word_idx, match_addr}, {23'd0, exp_q.pop_front()});
        end
        if (busy && !rst && (vocab_addr < prev_vaddr)) wrap_seen = 1'b1;
        prev_vaddr = busy ? vocab_addr : '0;
    end

    // '|' in a string stands for NUL; unused bytes are NUL.
    task automatic load(input string v, input string q);
        for (int i = 0; i < 16; i++) begin
            vocab_mem[i] = '0;
            query_mem[i] = '0;
        end
        for (int i = 0; i < v.len() && i < 16; i++)
            vocab_mem[i] = (v[i] == "|") ? 8'd0 : v[i];
        for (int i = 0; i < q.len() && i < 16; i++)
            query_mem[i] = (q[i] == "|") ? 8'd0 : q[i];
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
        check({tag, "_outs"}, {25'd0, busy, done, hit, word_idx[0], match_addr[0], vocab_addr[0], input_addr[0]}, 0);
        check({tag, "_addrs"}, {16'd0, word_idx, match_addr, vocab_addr, input_addr}, 0);
    endtask

    // lat/exp_vaddr < 0 means "don't check"; extra_start re-pulses start while busy.
    task automatic run_lookup(input string tag, input logic eh, input logic [AW-1:0] ei,
                              input logic [AW-1:0] ea, input int lat, input int exp_vaddr,
                              input bit extra_start);
        int  n;
        bit  busy_ok;
        int  dc0;
        dc0 = done_count;
        wrap_seen = 1'b0;
        busy_ok = 1'b1;
        exp_q.push_back({eh, eh ? ei : word_idx, eh ? ea : match_addr});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 300) begin
            if (!busy) busy_ok = 1'b0;
            if (extra_start) start = (n == 3 || n == 4 || n == 7);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            check({tag, "_timeout"}, 0, 1);
            void'(exp_q.pop_back());
            return;
        end
        check({tag, "_busy_during"}, 32'(busy_ok && busy), 1);
        if (lat >= 0) check({tag, "_latency"}, n, lat);
        if (exp_vaddr >= 0) check({tag, "_vaddr_end"}, 32'(vocab_addr), exp_vaddr);
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 0);
        check({tag, "_done_count"}, done_count - dc0, 1);
        check({tag, "_no_wrap"}, 32'(wrap_seen), 0);
        check({tag, "_hit_held"}, 32'(hit), 32'(eh));
    endtask

    initial begin
        load("cat|dog||", "cat|");
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        run_lookup("cat",  1'b1, 4'd0, 4'd0, 9, 3, 1'b0);
        load("cat|dog||", "dog|");
        run_lookup("dog",  1'b1, 4'd1, 4'd4, -1, 7, 1'b0);
        load("cat|dog||", "ca|");
        run_lookup("prefix", 1'b0, 4'd0, 4'd0, -1, 8, 1'b0);
        load("cat|dog||", "cats|");
        run_lookup("extension", 1'b0, 4'd0, 4'd0, -1, 8, 1'b0);
        load("cat|dog||", "|");
        run_lookup("empty_q", 1'b0, 4'd0, 4'd0, -1, 8, 1'b0);
        load("cat|dog||", "cow|");
        run_lookup("cow", 1'b0, 4'd0, 4'd0, -1, 8, 1'b0);
        load("aaaaaaaaaaaaaaaa", "x|");
        run_lookup("overflow", 1'b0, 4'd0, 4'd0, -1, 15, 1'b0);

        // Reset while skipping through "cat" for query "dog".
        load("cat|dog||", "dog|");
        run_lookup("pre_rst", 1'b1, 4'd1, 4'd4, -1, 7, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && state_dbg != SKIP_CHECK; i++) @(negedge clk);
        check("reach_skip_check", 32'(state_dbg), 32'(SKIP_CHECK));
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        rst = 1'b0;
        run_lookup("after_rst", 1'b1, 4'd1, 4'd4, -1, 7, 1'b0);

        load("cat|dog||", "cat|");
        run_lookup("restart_ignored", 1'b1, 4'd0, 4'd0, 9, 3, 1'b1);

        // Random queries drawn from the vocab, or a random non-word.
        for (int k = 0; k < 6; k++) begin
            int sel;
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                load("ab|cd|efg||", "ab|");
                run_lookup("rand_w0", 1'b1, 4'd0, 4'd0, 7, -1, 1'b0);
            end else if (sel == 1) begin
                load("ab|cd|efg||", "efg|");
                run_lookup("rand_w2", 1'b1, 4'd2, 4'd6, -1, 9, 1'b0);
            end else begin
                load("ab|cd|efg||", "cz|");
                run_lookup("rand_miss", 1'b0, 4'd0, 4'd0, -1, 10, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
